// File: rtl/beehive_nib_credit_fifo.sv
// Receive end of the valid/yummy credit link: a first-word-fall-through flit buffer
// that returns one registered yummy pulse per flit consumed.
module beehive_nib_credit_fifo #(
    parameter int DATA_WIDTH  = 64,
    parameter int BUFFER_SIZE = 4,
    parameter int BUFFER_BITS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   valid_in,
    output logic                   yummy_out,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_val,
    input  logic                   thanks_in,
    output logic [BUFFER_BITS-1:0] occupancy,
    output logic                   overflow_err
);

    localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(BUFFER_SIZE - 1);
    localparam logic [BUFFER_BITS-1:0] FULL_CNT = BUFFER_BITS'(BUFFER_SIZE);

    // Explicit wrap so non-power-of-two depths index only valid slots.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    logic [DATA_WIDTH-1:0]  storage [BUFFER_SIZE];
    logic [PTR_W-1:0]       head_f;
    logic [PTR_W-1:0]       tail_f;
    logic [BUFFER_BITS-1:0] count_f;
    logic [BUFFER_BITS-1:0] count_nxt;
    logic                   yummy_f;
    logic                   overflow_f;
    logic                   deq;
    logic                   enq;

    // A full buffer still accepts when the head leaves in the same cycle.
    assign deq = thanks_in & (count_f != '0);
    assign enq = valid_in & ((count_f != FULL_CNT) | deq);

    always_comb begin
        count_nxt = count_f;
        case ({enq, deq})
            2'b10:   count_nxt = count_f + BUFFER_BITS'(1);
            2'b01:   count_nxt = count_f - BUFFER_BITS'(1);
            default: count_nxt = count_f;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_f     <= '0;
            tail_f     <= '0;
            count_f    <= '0;
            yummy_f    <= 1'b0;
            overflow_f <= 1'b0;
        end else begin
            if (enq) tail_f <= ptr_inc(tail_f);
            if (deq) head_f <= ptr_inc(head_f);
            count_f <= count_nxt;
            yummy_f <= deq;
            if (valid_in & ~enq) overflow_f <= 1'b1;
        end
    end

    // Data storage carries no reset; validity is tracked solely by count_f.
    always_ff @(posedge clk) begin
        if (enq) storage[tail_f] <= data_in;
    end

    assign data_val     = (count_f != '0);
    assign data_out     = data_val ? storage[head_f] : '0;
    assign yummy_out    = yummy_f;
    assign occupancy    = count_f;
    assign overflow_err = overflow_f;

endmodule

// File: tb/tb_beehive_nib_credit_fifo.sv
// Directed vector table on a depth-4 buffer plus a randomised credit-link run on a depth-3 buffer.
module tb_beehive_nib_credit_fifo;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Depth-4 instance for directed vectors
    logic        reset, valid_in, thanks_in;
    logic [63:0] data_in;
    logic        yummy_out, data_val, overflow_err;
    logic [63:0] data_out;
    logic [2:0]  occupancy;

    beehive_nib_credit_fifo #(.DATA_WIDTH(64), .BUFFER_SIZE(4), .BUFFER_BITS(3)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .yummy_out(yummy_out), .data_out(data_out), .data_val(data_val),
        .thanks_in(thanks_in), .occupancy(occupancy), .overflow_err(overflow_err)
    );

    // Depth-3 instance for the random credit-link run
    logic        r_reset, r_valid, r_thanks;
    logic [15:0] r_din;
    logic        r_yummy, r_val, r_ovf;
    logic [15:0] r_dout;
    logic [1:0]  r_occ;

    beehive_nib_credit_fifo #(.DATA_WIDTH(16), .BUFFER_SIZE(3), .BUFFER_BITS(2)) dut3 (
        .clk(clk), .reset(r_reset), .data_in(r_din), .valid_in(r_valid),
        .yummy_out(r_yummy), .data_out(r_dout), .data_val(r_val),
        .thanks_in(r_thanks), .occupancy(r_occ), .overflow_err(r_ovf)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic [63:0] d;
        logic        t;
        logic        ev;
        logic [63:0] ed;
        logic        ey;
        logic [2:0]  eo;
        logic        eovf;
    } vec_t;

    vec_t vecs[$];

    // Each row: inputs driven for one clock edge, expected outputs just after that edge.
    task automatic add(input logic rst, input logic v, input logic [63:0] d, input logic t,
                       input logic ev, input logic [63:0] ed, input logic ey,
                       input logic [2:0] eo, input logic eovf);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.t = t;
        r.ev = ev; r.ed = ed; r.ey = ey; r.eo = eo; r.eovf = eovf;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0; valid_in = 1'b0; thanks_in = 1'b0; data_in = '0;
        r_reset = 1'b1; r_valid = 1'b0; r_thanks = 1'b0; r_din = '0;

        // reset then idle
        add(1,0,0,0, 0,0,0,0,0);
        add(1,0,0,0, 0,0,0,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0,0, 0,0,0,0,0);
        // fill with A1..A4
        add(0,1,64'hA1,0, 1,64'hA1,0,1,0);
        add(0,1,64'hA2,0, 1,64'hA1,0,2,0);
        add(0,1,64'hA3,0, 1,64'hA1,0,3,0);
        add(0,1,64'hA4,0, 1,64'hA1,0,4,0);
        // drain: yummy follows each thanks by one cycle
        add(0,0,0,1, 1,64'hA2,1,3,0);
        add(0,0,0,1, 1,64'hA3,1,2,0);
        add(0,0,0,1, 1,64'hA4,1,1,0);
        add(0,0,0,1, 0,0,1,0,0);
        add(0,0,0,0, 0,0,0,0,0);
        // full with simultaneous enq+deq
        add(0,1,64'hB1,0, 1,64'hB1,0,1,0);
        add(0,1,64'hB2,0, 1,64'hB1,0,2,0);
        add(0,1,64'hB3,0, 1,64'hB1,0,3,0);
        add(0,1,64'hB4,0, 1,64'hB1,0,4,0);
        add(0,1,64'hB5,1, 1,64'hB2,1,4,0);
        add(0,0,0,1, 1,64'hB3,1,3,0);
        add(0,0,0,1, 1,64'hB4,1,2,0);
        add(0,0,0,1, 1,64'hB5,1,1,0);
        add(0,0,0,1, 0,0,1,0,0);
        add(0,0,0,0, 0,0,0,0,0);
        // overflow: DEAD dropped, error sticky
        add(0,1,64'hC1,0, 1,64'hC1,0,1,0);
        add(0,1,64'hC2,0, 1,64'hC1,0,2,0);
        add(0,1,64'hC3,0, 1,64'hC1,0,3,0);
        add(0,1,64'hC4,0, 1,64'hC1,0,4,0);
        add(0,1,64'hDEAD,0, 1,64'hC1,0,4,1);
        add(0,0,0,0, 1,64'hC1,0,4,1);
        add(0,0,0,1, 1,64'hC2,1,3,1);
        add(0,0,0,1, 1,64'hC3,1,2,1);
        // reset while non-empty: contents discarded, no yummy
        add(1,0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0);
        // thanks held while empty, then one push
        add(0,0,0,1, 0,0,0,0,0);
        add(0,0,0,1, 0,0,0,0,0);
        add(0,0,0,1, 0,0,0,0,0);
        add(0,1,64'hC3,1, 1,64'hC3,0,1,0);
        add(0,0,0,1, 0,0,1,0,0);
        add(0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; valid_in = vecs[i].v; data_in = vecs[i].d; thanks_in = vecs[i].t;
            @(posedge clk); #1;
            chk("data_val",  i, {63'd0, data_val},     {63'd0, vecs[i].ev});
            chk("data_out",  i, data_out,              vecs[i].ed);
            chk("yummy_out", i, {63'd0, yummy_out},    {63'd0, vecs[i].ey});
            chk("occupancy", i, {61'd0, occupancy},    {61'd0, vecs[i].eo});
            chk("overflow",  i, {63'd0, overflow_err}, {63'd0, vecs[i].eovf});
        end
        reset = 1'b0; valid_in = 1'b0; thanks_in = 1'b0;

        // Random run: sender with 3 credits, consumer thanks at random
        begin
            int          credits;
            logic [15:0] sent[$];
            logic [15:0] seq;
            logic        send;
            credits = 3;
            seq = 16'h0100;
            @(negedge clk); @(negedge clk);
            r_reset = 1'b0;
            for (int c = 0; c < 10000; c++) begin
                @(negedge clk);
                chk("credit_inv", c, 64'(credits + int'(r_occ) + int'(r_yummy)), 64'd3);
                r_thanks = ($urandom_range(0, 2) != 0);
                if (r_thanks && r_val) begin
                    if (sent.size() == 0) chk("order_empty", c, {48'd0, r_dout}, 64'hFFFF_FFFF);
                    else                  chk("order", c, {48'd0, r_dout}, {48'd0, sent.pop_front()});
                end
                send = (credits > 0) && ($urandom_range(0, 1) == 1);
                r_valid = send;
                r_din = seq;
                if (send) begin
                    sent.push_back(seq);
                    seq = seq + 16'd1;
                end
                credits = credits - int'(send) + int'(r_yummy);
            end
            @(negedge clk);
            r_valid = 1'b0; r_thanks = 1'b0;
            chk("rand_overflow", 0, {63'd0, r_ovf}, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
